// File: rtl/push_cond_pkg.sv
// Shared types and constants for the push_cond input conditioning stage.
package push_cond_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/push_cond_sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; every bit is
// synchronized independently and resets to zero.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/push_cond.sv
// Button debounce and BCD digit capture feeding the triangle control FSM.
// Define PUSH_COND_AUTOREPEAT_EN to repeat events while the button is held.
module push_cond
    import push_cond_pkg::*;
#(
    parameter int DEB_CYCLES = 16,
    parameter int CNT_W      = 16,
    parameter int RPT_DELAY  = 64,
    parameter int RPT_PERIOD = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_raw,
    input  logic [3:0] din_raw,
    output logic       push,
    output logic       err,
    output logic [3:0] dout,
    output logic       busy
);

    // The IDLE sample is the first stable one, so acceptance happens on
    // the edge where the counter reaches DEB_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(DEB_CYCLES - 2);

    logic             btn_s;
    logic [3:0]       din_s;
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             push_n, err_n;
    logic [3:0]       dout_n;
    logic             accept;

    sync_2ff #(.WIDTH(1)) u_sync_btn (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (btn_raw),
        .q       (btn_s)
    );

    sync_2ff #(.WIDTH(4)) u_sync_din (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (din_raw),
        .q       (din_s)
    );

`ifdef PUSH_COND_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RPT_LAST   = CNT_W'(RPT_DELAY - 1);
    localparam logic [CNT_W-1:0] RPT_RELOAD = CNT_W'(RPT_DELAY - RPT_PERIOD);

    logic [CNT_W-1:0] rpt, rpt_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rpt <= '0;
        else          rpt <= rpt_n;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            push  <= 1'b0;
            err   <= 1'b0;
            dout  <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            push  <= push_n;
            err   <= err_n;
            dout  <= dout_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        push_n  = 1'b0;
        err_n   = 1'b0;
        dout_n  = dout;
        accept  = 1'b0;
`ifdef PUSH_COND_AUTOREPEAT_EN
        rpt_n   = '0;
`endif
        unique case (state)
            IDLE: begin
                if (btn_s) begin
                    state_n = PRESS_WAIT;
                    cnt_n   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_n = IDLE;
                end else begin
                    if (cnt != CNT_LAST) cnt_n = cnt + CNT_W'(1);
                    if (cnt == CNT_PRE) begin
                        state_n = HELD;
                        accept  = 1'b1;
                    end
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_n = RELEASE_WAIT;
                    cnt_n   = '0;
                end
`ifdef PUSH_COND_AUTOREPEAT_EN
                else if (rpt == RPT_LAST) begin
                    accept = 1'b1;
                    rpt_n  = RPT_RELOAD;
                end else begin
                    rpt_n = rpt + CNT_W'(1);
                end
`endif
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_n = HELD;
                end else begin
                    if (cnt != CNT_LAST) cnt_n = cnt + CNT_W'(1);
                    if (cnt == CNT_PRE) state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // Digit is sampled only once the button is known stable.
        if (accept) begin
            if (din_s <= BCD_MAX) begin
                push_n = 1'b1;
                dout_n = din_s;
            end else begin
                err_n = 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_push_cond.sv
// Self-checking bench for push_cond: vector table, corner sequences and
// random stimulus against a run-length debounce reference model.
module tb_push_cond;

    localparam int DEB  = 4;
    localparam int RDLY = 8;
    localparam int RPER = 4;
`ifdef PUSH_COND_AUTOREPEAT_EN
    localparam bit RPT = 1'b1;
`else
    localparam bit RPT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       btn_raw;
    logic [3:0] din_raw;
    logic       push;
    logic       err;
    logic [3:0] dout;
    logic       busy;

    int total = 0;
    int bad   = 0;

    push_cond #(
        .DEB_CYCLES (DEB),
        .CNT_W      (16),
        .RPT_DELAY  (RDLY),
        .RPT_PERIOD (RPER)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_raw (btn_raw),
        .din_raw (din_raw),
        .push    (push),
        .err     (err),
        .dout    (dout),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Reference model: accepted level flips after DEB consecutive
    // synchronized samples that disagree with it.
    logic       m_s1, m_s2;
    logic [3:0] m_d1, m_d2;
    logic       m_acc;
    int         m_run;
    int         m_hold;
    logic       m_push, m_err, m_busy;
    logic [3:0] m_dout;

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_d1 = 0; m_d2 = 0;
        m_acc = 0; m_run = 0; m_hold = 0;
        m_push = 0; m_err = 0; m_busy = 0; m_dout = 0;
    endtask

    task automatic model_edge(input logic b, input logic [3:0] d);
        logic       s;
        logic [3:0] ds;
        logic       held;
        logic       evt;
        s = m_s2;
        ds = m_d2;
        m_s2 = m_s1; m_s1 = b;
        m_d2 = m_d1; m_d1 = d;
        held = m_acc && (m_run == 0);
        evt = 0;
        m_push = 0;
        m_err = 0;
        if (s != m_acc) begin
            m_run++;
            if (m_run == DEB) begin
                m_acc = s;
                m_run = 0;
                evt = s;
            end
        end else begin
            m_run = 0;
        end
        if (held && s) begin
            m_hold++;
            if (RPT && m_hold >= RDLY && (m_hold - RDLY) % RPER == 0)
                evt = 1;
        end else begin
            m_hold = 0;
        end
        if (evt) begin
            if (ds <= 4'd9) begin
                m_push = 1;
                m_dout = ds;
            end else begin
                m_err = 1;
            end
        end
        m_busy = m_acc || (m_run > 0);
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic b, input logic [3:0] d);
        btn_raw = b;
        din_raw = d;
        @(posedge clk);
        model_edge(b, d);
        #1;
    endtask

    typedef struct {
        logic [19:0] pat;
        int          len;
        logic [3:0]  din;
        int          n_push;
        int          n_err;
        logic [3:0]  end_dout;
        int          first;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int         np, ne, first;
        logic       excl, prev;
        logic       b;
        logic [3:0] d;
        logic [63:0] mask, emask;
        int         len;

        vecs[0] = '{20'hFFFFF, 20, 4'd7, RPT ? 4 : 1, 0, 4'd7, 5};
        vecs[1] = '{20'h0001B, 6, 4'd5, 0, 0, 4'd7, -1};
        vecs[2] = '{20'h0FFFF, 16, 4'hC, 0, RPT ? 3 : 1, 4'd7, 5};
        vecs[3] = '{20'h05BFF, 15, 4'd2, 1, 0, 4'd2, 5};
        vecs[4] = '{20'h00007, 3, 4'd8, 0, 0, 4'd2, -1};
        vecs[5] = '{20'h0000F, 4, 4'd9, 1, 0, 4'd9, 5};
        vecs[6] = '{20'h000FF, 8, 4'hA, 0, 1, 4'd9, 5};
        vecs[7] = '{20'h000FF, 8, 4'd0, 1, 0, 4'd0, 5};
        vecs[8] = '{20'h000FF, 8, 4'd6, 1, 0, 4'd6, 5};

        reset_n = 0;
        btn_raw = 0;
        din_raw = 0;
        model_reset();
        #12;
        chk("reset_outs", {push, err, dout, busy}, 7'd0);
        @(negedge clk);
        reset_n = 1;

        foreach (vecs[v]) begin
            np = 0; ne = 0; first = -1; excl = 0; prev = 0;
            for (int i = 0; i < vecs[v].len + 12; i++) begin
                b = (i < vecs[v].len) ? vecs[v].pat[i] : 1'b0;
                cyc(b, vecs[v].din);
                if (push) np++;
                if (err) ne++;
                if ((push || err) && first < 0) first = i;
                if (push && err) excl = 1;
                if ((push || err) && prev) excl = 1;
                prev = push | err;
            end
            chk($sformatf("v%0d_push", v), np, vecs[v].n_push);
            chk($sformatf("v%0d_err", v), ne, vecs[v].n_err);
            chk($sformatf("v%0d_dout", v), dout, vecs[v].end_dout);
            chk($sformatf("v%0d_first", v), first, vecs[v].first);
            chk($sformatf("v%0d_idle", v), busy, 1'b0);
            chk($sformatf("v%0d_excl", v), excl, 1'b0);
        end

        // Reset while PRESS_WAIT holds counter 2, button kept high.
        for (int i = 0; i < 5; i++) cyc(1'b1, 4'd4);
        chk("pw_busy", {push, busy}, 2'b01);
        #2 reset_n = 0;
        #1 chk("rst_async", {push, err, dout, busy}, 7'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1;
        np = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 4'd4);
            if (push) np++;
            if (i == 5) chk("rst_lat_push", push, 1'b1);
        end
        chk("rst_push_cnt", np, 1);
        chk("rst_dout", dout, 4'd4);
        for (int i = 0; i < 12; i++) cyc(1'b0, 4'd4);
        chk("rst_idle", busy, 1'b0);

`ifdef PUSH_COND_AUTOREPEAT_EN
        mask = 0;
        for (int i = 0; i < 36; i++) begin
            cyc(i < 30, 4'd3);
            if (push) mask[i] = 1'b1;
        end
        emask = (64'd1 << 5) | (64'd1 << 13) | (64'd1 << 17) |
                (64'd1 << 21) | (64'd1 << 25) | (64'd1 << 29);
        chk("rpt_mask", mask, emask);
        chk("rpt_dout", dout, 4'd3);
        for (int i = 0; i < 12; i++) cyc(1'b0, 4'd3);
`else
        mask = 0;
        for (int i = 0; i < 36; i++) begin
            cyc(i < 30, 4'd3);
            if (push) mask[i] = 1'b1;
        end
        emask = 64'd1 << 5;
        chk("hold_mask", mask, emask);
        for (int i = 0; i < 12; i++) cyc(1'b0, 4'd3);
`endif

        b = 0;
        d = 4'd0;
        for (int r = 0; r < 500; r++) begin
            b = ~b;
            len = ($urandom_range(0, 5) == 0) ? $urandom_range(15, 40)
                                              : $urandom_range(1, 7);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 7) == 0) d = 4'($urandom_range(0, 15));
                cyc(b, d);
                chk("model", {push, err, dout, busy},
                    {m_push, m_err, m_dout, m_busy});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/push_cond.md
Name: push_cond

Overview:
- Input conditioning stage directly upstream of the triangle generator's control FSM.
- Takes a raw, bouncy push button and raw 4-bit switch value, both asynchronous.
- Produces a clean single-cycle `push` pulse plus a stable, BCD-validated `dout` digit, so the control FSM sees one event per physical press and never a non-BCD limit.

Parameters:
- DEB_CYCLES, 16, consecutive stable synchronized samples required to accept a press or release (≥2).
- CNT_W, 16, debounce counter width; must hold DEB_CYCLES-1.
- RPT_DELAY, 64, cycles held in HELD before the first auto-repeat (AUTOREPEAT_EN only).
- RPT_PERIOD, 32, cycles between subsequent auto-repeats (AUTOREPEAT_EN only).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- btn_raw  input  1  raw push button, active high, asynchronous, may bounce
- din_raw  input  4  raw switch value, asynchronous
- push  output  1  one-cycle pulse: accepted press with valid BCD digit
- err  output  1  one-cycle pulse: accepted press with digit > 9
- dout  output  4  last accepted BCD digit, held between presses
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, counter=0.
  - All synchronizer flops 0.
  - push=0, err=0, dout=4'd0, busy=0.
- Synchronization:
  - btn_raw and din_raw each pass through a 2-flop synchronizer, giving btn_s and din_s.
  - din bits are synchronized independently. Skew is tolerated because din_s is sampled only after DEB_CYCLES of button stability.
- States: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
- IDLE:
  - btn_s=1 → PRESS_WAIT, counter=0.
- PRESS_WAIT:
  - btn_s=0 → IDLE (bounce rejected, no pulse).
  - btn_s=1 → counter+1.
  - btn_s=1 at counter==DEB_CYCLES-1 → HELD. On that same edge:
    - din_s ≤ 9: push=1 for one cycle and dout←din_s.
    - din_s > 9: err=1 for one cycle and dout unchanged.
- HELD:
  - btn_s=0 → RELEASE_WAIT, counter=0.
  - Holding produces no further pulses (without AUTOREPEAT_EN).
- RELEASE_WAIT:
  - btn_s=1 → HELD. Release bounce never re-triggers a press.
  - btn_s=0 at counter==DEB_CYCLES-1 → IDLE.
- Latency:
  - Let edge k be the first edge that samples btn_raw=1 into the synchronizer.
  - With the button held clean, push is high in the cycle after edge k+1+DEB_CYCLES (DEB_CYCLES+2 edges total).
- Simultaneous/boundary rules:
  - push and err are mutually exclusive and never high two consecutive cycles (without AUTOREPEAT_EN).
  - dout changes only on the edge that raises push.
  - Counter saturates at DEB_CYCLES-1 and never wraps.
  - Reset mid-debounce aborts with no pulse; post-reset requires a full fresh press.
  - din changes while HELD are ignored until the next accepted press.

Optional Feature:
- Macro: PUSH_COND_AUTOREPEAT_EN.
- Defined:
  - In HELD, a second counter runs.
  - After RPT_DELAY cycles a repeat event fires, then every RPT_PERIOD cycles while btn_s stays 1.
  - Each repeat re-samples din_s and applies the same push/err/dout rules.
  - Leaving HELD clears the repeat counter.
- Undefined:
  - Exactly one event per press.
  - No repeat counter or parameters are used (they are left unreferenced).

Decomposition:
- Shared package `push_cond_pkg`:
  - State enum (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT).
  - Constant BCD_MAX=4'd9.
- Natural sub-module `sync_2ff`:
  - Parameterised width, async active-low reset, resets to 0.
  - Instantiated for btn and din.

Test Plan (DEB_CYCLES=4, RPT_DELAY=8, RPT_PERIOD=4):
- Clean press: din_raw=4'd7, btn_raw 0→1 held 20 cycles → single push exactly 6 edges after first sampling edge, dout=7, err never high.
- Bounce reject: btn_raw toggles 1,1,0,1,1,0 per cycle then 0 → no push/err, state returns IDLE, dout unchanged.
- Invalid digit: din_raw=4'hC, clean press → err one cycle, push=0, dout keeps previous value 7.
- Release bounce: after accepted press, btn_raw 1→0→1→0 with gaps <4 cycles then low 10 cycles → no second push, busy drops once low is stable 4 samples.
- Reset mid-operation: assert reset_n=0 during PRESS_WAIT counter=2 → all outputs 0 immediately; release with btn_raw still high → push only after full DEB_CYCLES+2 edges.
- Auto-repeat (macro defined): din_raw=4'd3, hold 30 cycles → push at acceptance, then at +8, +12, +16…; dout=3 each time; stops on release.
